ps2_scancode_rx: RTL and testbench

PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_sync_filter.sv | 37 +++
 rtl/ps2_scancode_rx.sv | 163 ++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver types: frame FSM encoding, prefix bytes, FIFO entry layout.
// Also provides the odd-parity check used at the stop bit.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_REL = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_ent_t;

  function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
    return ^{dat, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus stability filter for one raw PS/2 line; filt follows raw
// about FILT_CYC+2 cycles late and only after the synchronised level has held FILT_CYC cycles.
module ps2_sync_filter #(
  parameter int FILT_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(FILT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYC - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      cnt  <= '0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      // Any return to the current filtered level restarts the stability count.
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: filtered frame FSM, E0/F0 prefix decode, FWFT scancode FIFO.
// Entry is pushed the cycle after the stop edge; keyboard cannot be stalled, so a full FIFO drops and sets sticky overflow.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILT_CYC    = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       CLK_100MHz,
  input  logic       RST,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rd_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic clk_f, data_f, clk_prev, fall;

  ps2_sync_filter #(.FILT_CYC(FILT_CYC)) u_clk_filt (
    .clk (CLK_100MHz),
    .rst (RST),
    .raw (ps2_clk),
    .filt(clk_f)
  );

  ps2_sync_filter #(.FILT_CYC(FILT_CYC)) u_data_filt (
    .clk (CLK_100MHz),
    .rst (RST),
    .raw (ps2_data),
    .filt(data_f)
  );

  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) clk_prev <= 1'b1;
    else     clk_prev <= clk_f;
  end

  assign fall = clk_prev & ~clk_f;

  ps2_state_t    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_flag, rel_flag;
  logic          push_vld;
  key_ent_t      push_dat;

  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      ext_flag  <= 1'b0;
      rel_flag  <= 1'b0;
      push_vld  <= 1'b0;
      push_dat  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      push_vld  <= 1'b0;
      if (state == ST_IDLE || fall) to_cnt <= '0;
      else                          to_cnt <= to_cnt + TW'(1);

      case (state)
        ST_IDLE: begin
          if (fall && !data_f) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (fall) begin
            shreg   <= {data_f, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (fall) begin
            par_bit <= data_f;
            state   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall) begin
            state <= ST_IDLE;
            if (odd_parity_ok(shreg, par_bit) && data_f) begin
              if (shreg == PS2_EXT) begin
                ext_flag <= 1'b1;
              end else if (shreg == PS2_REL) begin
                rel_flag <= 1'b1;
              end else begin
                push_vld <= 1'b1;
                push_dat <= {ext_flag, rel_flag, shreg};
                ext_flag <= 1'b0;
                rel_flag <= 1'b0;
              end
            end else begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              rel_flag  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A stalled keyboard mid-frame abandons the frame and any pending prefix.
      if (state != ST_IDLE && !fall && to_cnt == TO_LAST) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        rel_flag  <= 1'b0;
      end
    end
  end

  key_ent_t  mem [FIFO_DEPTH];
  key_ent_t  head;
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, pop, push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rd_en && !empty;
  assign push  = push_vld && (!full || pop);

  always_ff @(posedge CLK_100MHz) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge CLK_100MHz or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_vld && full && !pop) overflow <= 1'b1;
    end
  end

  assign head         = mem[rd_ptr[AW-1:0]];
  assign key_valid    = !empty;
  assign key_code     = key_valid ? head.code : 8'h00;
  assign key_release  = key_valid & head.rel;
  assign key_extended = key_valid & head.ext;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed PS/2 frames with a scoreboard: expected FIFO entries are queued as frames are sent
// and a negedge monitor pops and compares each entry as it is read out.
`timescale 1ns/1ps
module tb_ps2_scancode_rx;

  localparam int HB = 20;
  localparam int TO = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_release, key_extended, frame_err, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cycles = 0;
  int err_pulses = 0;
  logic err_d = 1'b0;
  bit auto_rd = 1'b0;
  bit pop_on_push = 1'b0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_scancode_rx #(.FIFO_DEPTH(8), .FILT_CYC(8), .TIMEOUT_CYC(TO)) dut (
    .CLK_100MHz  (clk),
    .RST         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd_en       (rd_en),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_release (key_release),
    .key_extended(key_extended),
    .frame_err   (frame_err),
    .overflow    (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitor: count frame_err pulses, drive reads, compare each popped head against the queue.
  always @(negedge clk) begin
    logic [9:0] want;
    if (frame_err === 1'b1) begin
      err_cycles++;
      if (err_d !== 1'b1) err_pulses++;
    end
    err_d = frame_err;
    rd_en = key_valid && (auto_rd || (pop_on_push && dut.push_vld));
    if (rd_en) begin
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
      chk("fifo_head", {22'd0, key_extended, key_release, key_code}, {22'd0, want});
    end
  end

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (HB) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HB) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HB) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit bad);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    send_bits(f, 11);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || key_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_valid"}, {31'd0, key_valid}, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, key_valid}, 0);
    chk({tag, "_code"}, {24'd0, key_code}, 0);
    chk({tag, "_rel"}, {31'd0, key_release}, 0);
    chk({tag, "_ext"}, {31'd0, key_extended}, 0);
    chk({tag, "_err"}, {31'd0, frame_err}, 0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 0);
  endtask

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst0");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    auto_rd = 1'b1;

    // Plain make code
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 0);
    drain("make_1c");

    // Break code
    exp_q.push_back({2'b01, 8'h1C});
    send(8'hF0, 0);
    send(8'h1C, 0);
    drain("brk_1c");

    // Extended break
    exp_q.push_back({2'b11, 8'h75});
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 0);
    drain("ext_brk_75");

    // Bad parity after E0 discards the byte and the prefix
    e0 = err_pulses;
    send(8'hE0, 0);
    send(8'h1C, 1);
    repeat (30) @(negedge clk);
    chk("parity_err_pulse", err_pulses, e0 + 1);
    chk("parity_no_entry", {31'd0, key_valid}, 0);
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 0);
    drain("after_parity");

    // Nine keys without reads: ninth dropped, overflow set
    auto_rd = 1'b0;
    for (int k = 8'h15; k <= 8'h1D; k++) begin
      if (k <= 8'h1C) exp_q.push_back({2'b00, 8'(k)});
      send(8'(k), 0);
    end
    repeat (30) @(negedge clk);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_head", {24'd0, key_code}, 32'h15);
    auto_rd = 1'b1;
    drain("ovf_drain");
    chk("ovf_sticky", {31'd0, overflow}, 1);

    // Full FIFO with push and pop in the same cycle: no drop
    auto_rd = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ovf_clr", {31'd0, overflow}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 8'h15; k <= 8'h1C; k++) begin
      exp_q.push_back({2'b00, 8'(k)});
      send(8'(k), 0);
    end
    pop_on_push = 1'b1;
    exp_q.push_back({2'b00, 8'h1D});
    send(8'h1D, 0);
    pop_on_push = 1'b0;
    chk("pushpop_no_ovf", {31'd0, overflow}, 0);
    chk("pushpop_left", exp_q.size(), 8);
    auto_rd = 1'b1;
    drain("pushpop_drain");

    // Timeout mid-frame after E0
    e0 = err_pulses;
    send(8'hE0, 0);
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    repeat (400) @(negedge clk);
    chk("timeout_not_early", err_pulses, e0);
    repeat (300) @(negedge clk);
    chk("timeout_pulse", err_pulses, e0 + 1);
    exp_q.push_back({2'b00, 8'h29});
    send(8'h29, 0);
    drain("after_timeout");

    // Reset mid-frame
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst_mid");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    exp_q.push_back({2'b00, 8'h29});
    send(8'h29, 0);
    drain("after_rst");

    chk("err_total", err_pulses, 2);
    chk("err_width", err_cycles, err_pulses);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
